// File: rtl/pe_tile_seq.sv
// pe_tile_seq: sequences one INT4 counting PE through clear, operand feed,
// drain and a word-serial readout of its counters.
module pe_tile_seq #(
    parameter int unsigned WORD_SIZE    = 4,
    parameter int unsigned REG_SIZE     = 16,
    parameter int unsigned NUM_CNT      = 29,
    parameter int unsigned K_WIDTH      = 12,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [K_WIDTH-1:0]          k_len,
    output logic                        busy,
    output logic                        done,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic [WORD_SIZE-1:0]        op_left,
    input  logic [WORD_SIZE-1:0]        op_top,
    output logic                        pe_rst,
    output logic [WORD_SIZE-1:0]        pe_left,
    output logic [WORD_SIZE-1:0]        pe_top,
    output logic                        pe_fsm_out_select,
    input  logic [NUM_CNT*REG_SIZE-1:0] pe_counter,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [REG_SIZE-1:0]         rd_data,
    output logic [4:0]                  rd_index,
    output logic                        rd_last
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [K_WIDTH-1:0]   k_reg;
    logic [K_WIDTH-1:0]   beat_cnt;
    logic [DRN_W-1:0]     drain_cnt;
    logic                 accept;
    logic [IDX_W-1:0]     idx_inc;
    logic [REG_SIZE-1:0]  cnt_word [NUM_CNT];

    logic                 pe_rst_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 sel_d;
    logic                 rd_valid_d;
    logic [WORD_SIZE-1:0] pe_left_d;
    logic [WORD_SIZE-1:0] pe_top_d;

    // Split the flat PE counter bus into addressable words
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        assign cnt_word[g] = pe_counter[g*REG_SIZE +: REG_SIZE];
    end

    assign accept   = (state == S_FEED) && op_valid;
    assign op_ready = (state == S_FEED);
    assign idx_inc  = IDX_W'(rd_index + IDX_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = (k_reg == '0) ? S_DRAIN : S_FEED;
            S_FEED:  if (accept && (K_WIDTH'(beat_cnt + K_WIDTH'(1)) == k_reg)) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == DRN_W'(DRAIN_CYCLES - 1)) state_nxt = S_READ;
            S_READ:  if (rd_ready && rd_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: values the output registers take on the coming edge
    always_comb begin
        pe_rst_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        sel_d      = 1'b0;
        rd_valid_d = 1'b0;
        pe_left_d  = '0;
        pe_top_d   = '0;
        pe_rst_d   = (state_nxt == S_CLEAR);
        busy_d     = (state_nxt != S_IDLE);
        done_d     = (state_nxt == S_DONE);
        sel_d      = (state_nxt == S_FEED) || (state_nxt == S_DRAIN);
        rd_valid_d = (state_nxt == S_READ);
        if (accept) begin
            pe_left_d = op_left;
            pe_top_d  = op_top;
        end
    end

    // Output registers, job counters and readout datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_rst            <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            pe_fsm_out_select <= 1'b0;
            rd_valid          <= 1'b0;
            pe_left           <= '0;
            pe_top            <= '0;
            k_reg             <= '0;
            beat_cnt          <= '0;
            drain_cnt         <= '0;
            rd_index          <= '0;
            rd_data           <= '0;
            rd_last           <= 1'b0;
        end else begin
            pe_rst            <= pe_rst_d;
            busy              <= busy_d;
            done              <= done_d;
            pe_fsm_out_select <= sel_d;
            rd_valid          <= rd_valid_d;
            pe_left           <= pe_left_d;
            pe_top            <= pe_top_d;

            if ((state == S_IDLE) && start) begin
                k_reg <= k_len;
            end

            if (state == S_CLEAR) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= K_WIDTH'(beat_cnt + K_WIDTH'(1));
            end

            if (state == S_DRAIN) begin
                drain_cnt <= DRN_W'(drain_cnt + DRN_W'(1));
            end else begin
                drain_cnt <= '0;
            end

            if ((state != S_READ) && (state_nxt == S_READ)) begin
                rd_index <= '0;
                rd_data  <= cnt_word[0];
                rd_last  <= (NUM_CNT == 1);
            end else if ((state == S_READ) && rd_ready) begin
                if (rd_last) begin
                    rd_index <= '0;
                    rd_last  <= 1'b0;
                end else begin
                    rd_index <= idx_inc;
                    rd_data  <= cnt_word[idx_inc];
                    rd_last  <= (idx_inc == IDX_W'(NUM_CNT - 1));
                end
            end
        end
    end

endmodule
